// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master arbiter: field widths and FSM state encoding.
package spi_pkg;

    localparam int SPI_NBITS_W = 5;
    localparam int SPI_DATA_W  = 32;
    localparam int SPI_DIV_W   = 16;
    localparam int WDOG_W      = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CFG,
        ST_CFG_REL,
        ST_ABORT
    } arb_state_t;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module spi_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan downward from the farthest candidate so the nearest one to ptr is written last and wins.
    always_comb begin
        // NOTE: every output gets a default before the loop; otherwise a path that assigns nothing infers a latch.
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                onehot                        = '0;
                onehot[(int'(ptr) + k) % N]   = 1'b1;
                idx                           = IDX_W'((int'(ptr) + k) % N);
                valid                         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin sharing of one spi_master among NCLIENTS requesters, with divider reload
// sequencing (reset-time reload of the master) and a watchdog that aborts hung transfers.
module spi_master_arbiter
    import spi_pkg::*;
#(
    parameter int NCLIENTS = 2,
    parameter int TIMEOUT  = 8000000
) (
    input  logic                            clk_in,
    input  logic                            nrst,
    input  logic [NCLIENTS-1:0]             c_req,
    input  logic [SPI_NBITS_W*NCLIENTS-1:0] c_nbits,
    input  logic [SPI_DATA_W*NCLIENTS-1:0]  c_mosi,
    input  logic [NCLIENTS-1:0]             c_spi3w,
    output logic [NCLIENTS-1:0]             c_gnt,
    output logic [NCLIENTS-1:0]             c_done,
    output logic [NCLIENTS-1:0]             c_err,
    output logic [SPI_DATA_W-1:0]           rd_data,
    input  logic                            cfg_div_we,
    input  logic [SPI_DIV_W-1:0]            cfg_div,
    output logic                            cfg_busy,
    output logic                            m_nrst,
    output logic                            m_request,
    output logic [SPI_NBITS_W-1:0]          m_nbits,
    output logic [SPI_DATA_W-1:0]           m_mosi_data,
    output logic                            m_spi3w,
    input  logic [SPI_DATA_W-1:0]           m_miso_data,
    input  logic                            m_ready
);

    localparam int                IDX_W     = $clog2(NCLIENTS);
    localparam logic [WDOG_W-1:0] TIMEOUT_C = WDOG_W'(TIMEOUT);

    arb_state_t           state, state_n;
    logic                 sub, sub_n;            // second-cycle marker for CFG and ABORT
    logic [IDX_W-1:0]     ptr, ptr_n;
    logic [IDX_W-1:0]     gidx, gidx_n;
    logic                 pending, pending_n;
    logic [SPI_DIV_W-1:0] div_lat, div_lat_n;
    logic [WDOG_W-1:0]    wdog, wdog_n;

    logic [NCLIENTS-1:0]    gnt_n, done_n, err_n;
    logic [SPI_DATA_W-1:0]  rd_n, mosi_n;
    logic [SPI_NBITS_W-1:0] nbits_n;
    logic                   mnrst_n, mreq_n, spi3w_n, busy_n;

    logic [NCLIENTS-1:0] pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [IDX_W-1:0]    gidx_inc;

    spi_rr_pick #(.N(NCLIENTS), .IDX_W(IDX_W)) u_pick (
        .req    (c_req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign gidx_inc = (gidx == IDX_W'(NCLIENTS - 1)) ? '0 : gidx + 1'b1;

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_n   = state;
        sub_n     = sub;
        ptr_n     = ptr;
        gidx_n    = gidx;
        pending_n = pending;
        div_lat_n = div_lat;
        wdog_n    = wdog;
        gnt_n     = c_gnt;
        done_n    = '0;
        err_n     = '0;
        rd_n      = rd_data;
        mnrst_n   = m_nrst;
        mreq_n    = m_request;
        nbits_n   = m_nbits;
        mosi_n    = m_mosi_data;
        spi3w_n   = m_spi3w;

        unique case (state)
            ST_IDLE: begin
                mnrst_n = 1'b1;
                mreq_n  = 1'b0;
                gnt_n   = '0;
                if (pending) begin
                    // The master loads its divider while held in reset with request high.
                    state_n   = ST_CFG;
                    pending_n = 1'b0;
                    sub_n     = 1'b0;
                    mnrst_n   = 1'b0;
                    mreq_n    = 1'b1;
                    nbits_n   = '0;
                    mosi_n    = {{(SPI_DATA_W - SPI_DIV_W){1'b0}}, div_lat};
                end else if (pick_valid) begin
                    state_n = ST_ISSUE;
                    gidx_n  = pick_idx;
                    gnt_n   = pick_onehot;
                    mreq_n  = 1'b1;
                    nbits_n = c_nbits[int'(pick_idx)*SPI_NBITS_W +: SPI_NBITS_W];
                    mosi_n  = c_mosi[int'(pick_idx)*SPI_DATA_W +: SPI_DATA_W];
                    spi3w_n = c_spi3w[pick_idx];
                end
            end
            ST_ISSUE: begin
                // Request is a single-cycle pulse so the master cannot re-trigger from Idle.
                mreq_n  = 1'b0;
                wdog_n  = '0;
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (m_ready) begin
                    rd_n         = m_miso_data;
                    done_n[gidx] = 1'b1;
                    ptr_n        = gidx_inc;
                    state_n      = ST_IDLE;
                end else if ((TIMEOUT != 0) && (wdog + 1'b1 == TIMEOUT_C)) begin
                    err_n[gidx] = 1'b1;
                    ptr_n       = gidx_inc;
                    mnrst_n     = 1'b0;
                    mreq_n      = 1'b0;
                    sub_n       = 1'b0;
                    state_n     = ST_ABORT;
                end else begin
                    wdog_n = wdog + 1'b1;
                end
            end
            ST_ABORT: begin
                gnt_n = '0;
                if (!sub) begin
                    sub_n = 1'b1;
                end else begin
                    mnrst_n = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_CFG: begin
                if (!sub) begin
                    sub_n = 1'b1;
                end else begin
                    mreq_n  = 1'b0;
                    state_n = ST_CFG_REL;
                end
            end
            ST_CFG_REL: begin
                mnrst_n = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        // A reload request is accepted in any state; a later write before service replaces the value.
        if (cfg_div_we) begin
            pending_n = 1'b1;
            div_lat_n = cfg_div;
        end
        busy_n = pending_n || (state_n == ST_CFG) || (state_n == ST_CFG_REL);
    end

    // State and registered outputs; async reset holds the master in reset too.
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            state       <= ST_IDLE;
            sub         <= 1'b0;
            ptr         <= '0;
            gidx        <= '0;
            pending     <= 1'b0;
            div_lat     <= '0;
            wdog        <= '0;
            c_gnt       <= '0;
            c_done      <= '0;
            c_err       <= '0;
            rd_data     <= '0;
            cfg_busy    <= 1'b0;
            m_nrst      <= 1'b0;
            m_request   <= 1'b0;
            m_nbits     <= '0;
            m_mosi_data <= '0;
            m_spi3w     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            state       <= state_n;
            sub         <= sub_n;
            ptr         <= ptr_n;
            gidx        <= gidx_n;
            pending     <= pending_n;
            div_lat     <= div_lat_n;
            wdog        <= wdog_n;
            c_gnt       <= gnt_n;
            c_done      <= done_n;
            c_err       <= err_n;
            rd_data     <= rd_n;
            cfg_busy    <= busy_n;
            m_nrst      <= mnrst_n;
            m_request   <= mreq_n;
            m_nbits     <= nbits_n;
            m_mosi_data <= mosi_n;
            m_spi3w     <= spi3w_n;
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter with a behavioural spi_master stand-in.
module tb_spi_master_arbiter;

    localparam int N      = 4;
    localparam int TO     = 100;
    localparam int BUDGET = 400;

    logic            clk_in = 1'b0;
    logic            nrst   = 1'b0;
    logic [N-1:0]    c_req   = '0;
    logic [N-1:0]    c_spi3w = '0;
    logic [5*N-1:0]  c_nbits = '0;
    logic [32*N-1:0] c_mosi  = '0;
    logic [N-1:0]    c_gnt, c_done, c_err;
    logic [31:0]     rd_data;
    logic            cfg_div_we = 1'b0;
    logic [15:0]     cfg_div    = '0;
    logic            cfg_busy, m_nrst, m_request, m_spi3w;
    logic [4:0]      m_nbits;
    logic [31:0]     m_mosi_data;
    logic [31:0]     m_miso_data = '0;
    logic            m_ready     = 1'b1;

    int checks   = 0;
    int failures = 0;

    spi_master_arbiter #(.NCLIENTS(N), .TIMEOUT(TO)) dut (
        .clk_in(clk_in), .nrst(nrst), .c_req(c_req), .c_nbits(c_nbits), .c_mosi(c_mosi),
        .c_spi3w(c_spi3w), .c_gnt(c_gnt), .c_done(c_done), .c_err(c_err), .rd_data(rd_data),
        .cfg_div_we(cfg_div_we), .cfg_div(cfg_div), .cfg_busy(cfg_busy), .m_nrst(m_nrst),
        .m_request(m_request), .m_nbits(m_nbits), .m_mosi_data(m_mosi_data), .m_spi3w(m_spi3w),
        .m_miso_data(m_miso_data), .m_ready(m_ready)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural master: takes nbits+1 cycles per transfer, returns ~mosi unless overridden.
    bit          hang = 1'b0;
    bit          ovr  = 1'b0;
    logic [31:0] ovr_word = '0;
    logic        mbusy = 1'b0;
    logic [5:0]  mcnt  = '0;
    logic [31:0] mresp = '0;
    logic [15:0] mdiv  = '0;

    always @(posedge clk_in) begin
        if (!m_nrst) begin
            m_ready <= 1'b1;
            mbusy   <= 1'b0;
            if (m_request) mdiv <= m_mosi_data[15:0];
        end else if (mbusy) begin
            if (!hang) begin
                if (mcnt == 6'd1) begin
                    m_ready     <= 1'b1;
                    mbusy       <= 1'b0;
                    m_miso_data <= mresp;
                end else begin
                    mcnt <= mcnt - 6'd1;
                end
            end
        end else if (m_request) begin
            m_ready <= 1'b0;
            mbusy   <= 1'b1;
            mcnt    <= 6'(m_nbits) + 6'd1;
            mresp   <= ovr ? ovr_word : ~m_mosi_data;
        end
    end

    // Whole-run monitors.
    int gnt_viol   = 0;
    int err_pulses = 0;
    always @(negedge clk_in) begin
        if ($countones(c_gnt) > 1) gnt_viol++;
        if (|c_err) err_pulses++;
    end

    // Client-side fields and the reference round-robin pointer.
    logic [4:0]  nb [N];
    logic [31:0] mo [N];
    logic        s3 [N];
    int          ptr_m = 0;

    typedef struct {
        int          cl;
        logic [4:0]  nbits;
        logic [31:0] mosi;
        logic        spi3w;
        bit          ovr;
        logic [31:0] slave;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic apply_fields();
        for (int i = 0; i < N; i++) begin
            c_nbits[5*i +: 5]   = nb[i];
            c_mosi[32*i +: 32]  = mo[i];
            c_spi3w[i]          = s3[i];
        end
    endtask

    // First requesting client at or after ptr, scanning upward with wrap.
    function automatic int model_pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++)
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET && !ok; i++) begin
            @(negedge clk_in);
            if (m_request && m_nrst) ok = 1'b1;
        end
    endtask

    task automatic wait_done(input int g, output bit ok, output int cycles, output int extra);
        ok = 1'b0; cycles = 0; extra = 0;
        while (!ok && cycles < BUDGET) begin
            @(negedge clk_in);
            cycles++;
            if (m_request && m_nrst) extra++;
            if (c_done[g]) ok = 1'b1;
        end
    endtask

    // One transfer expected for client g; drops every request on completion when last is set.
    task automatic do_one(input int g, input logic [31:0] exp_rd, input bit last);
        bit ok;
        int cyc, extra;
        wait_req(ok);
        check("req_seen", 32'(ok), 32'd1);
        if (!ok) begin c_req = '0; return; end
        check("gnt", 32'(c_gnt), 32'(1 << g));
        check("m_nbits", 32'(m_nbits), 32'(nb[g]));
        check("m_mosi", m_mosi_data, mo[g]);
        check("m_spi3w", 32'(m_spi3w), 32'(s3[g]));
        wait_done(g, ok, cyc, extra);
        check("done_seen", 32'(ok), 32'd1);
        check("latency", cyc, 32'(nb[g]) + 32'd3);
        check("single_request", extra, 0);
        check("rd_data", rd_data, exp_rd);
        check("gnt_in_done", 32'(c_gnt), 32'(1 << g));
        ptr_m = (g + 1) % N;
        if (last) begin
            c_req = '0;
            @(negedge clk_in);
            check("done_pulse_1cy", 32'(c_done), 32'd0);
            check("gnt_released", 32'(c_gnt), 32'd0);
        end
    endtask

    task automatic run_xfers(input logic [N-1:0] mask, input int count);
        int g;
        c_req = mask;
        for (int k = 0; k < count; k++) begin
            g = model_pick(mask, ptr_m);
            do_one(g, ~mo[g], k == count - 1);
        end
    endtask

    initial begin
        bit          ok;
        int          cyc, extra, g, o;
        logic [N-1:0] mask;
        logic        r_nrst [4];
        logic        r_req  [4];
        logic [4:0]  r_nb   [4];
        logic [31:0] r_mosi [4];
        logic        r_busy [4];

        vecs[0] = '{0, 5'd7,  32'hA500_0000, 1'b0, 1'b1, 32'h0000_003C, 32'h0000_003C};
        vecs[1] = '{1, 5'd31, 32'h1234_5678, 1'b1, 1'b0, 32'h0,         32'hEDCB_A987};
        vecs[2] = '{0, 5'd0,  32'h0000_0001, 1'b0, 1'b0, 32'h0,         32'hFFFF_FFFE};
        vecs[3] = '{1, 5'd15, 32'hFFFF_0000, 1'b0, 1'b0, 32'h0,         32'h0000_FFFF};
        vecs[4] = '{3, 5'd4,  32'h0F0F_0F0F, 1'b1, 1'b0, 32'h0,         32'hF0F0_F0F0};
        vecs[5] = '{2, 5'd20, 32'h8000_0000, 1'b0, 1'b0, 32'h0,         32'h7FFF_FFFF};
        for (int i = 0; i < N; i++) begin nb[i] = '0; mo[i] = '0; s3[i] = 1'b0; end
        apply_fields();

        // Reset state.
        repeat (3) @(negedge clk_in);
        check("rst_gnt", 32'(c_gnt), 32'd0);
        check("rst_m_nrst", 32'(m_nrst), 32'd0);
        check("rst_m_request", 32'(m_request), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_cfg_busy", 32'(cfg_busy), 32'd0);
        check("rst_m_mosi", m_mosi_data, 32'd0);
        nrst = 1'b1;
        @(negedge clk_in);
        check("m_nrst_release", 32'(m_nrst), 32'd1);

        // Table of single-client transfers; the first is the basic client-0 case.
        for (int v = 0; v < 6; v++) begin
            nb[vecs[v].cl] = vecs[v].nbits;
            mo[vecs[v].cl] = vecs[v].mosi;
            s3[vecs[v].cl] = vecs[v].spi3w;
            ovr            = vecs[v].ovr;
            ovr_word       = vecs[v].slave;
            apply_fields();
            c_req = N'(1 << vecs[v].cl);
            do_one(vecs[v].cl, vecs[v].exp_rd, 1'b1);
        end
        ovr = 1'b0;

        // Pointer sits at 3 now: requests 0 and 2 must wrap to client 0, then pointer is 1.
        nb[0] = 5'd3; mo[0] = 32'h0000_00FF;
        nb[1] = 5'd2; mo[1] = 32'hCAFE_0001;
        nb[2] = 5'd5; mo[2] = 32'h0BAD_F00D;
        apply_fields();
        c_req = 4'b0101;
        do_one(0, 32'hFFFF_FF00, 1'b1);
        c_req = 4'b0110;
        do_one(1, 32'h3501_FFFE, 1'b1);

        // Clients 0 and 1 held together alternate.
        for (int i = 0; i < 2; i++) begin
            nb[i] = 5'($urandom_range(0, 31)); mo[i] = $urandom; s3[i] = 1'($urandom);
        end
        apply_fields();
        run_xfers(4'b0011, 4);

        // Divider reload requested during a client-1 transfer; the second write wins.
        nb[1] = 5'd9; mo[1] = 32'h1357_9BDF; s3[1] = 1'b0;
        apply_fields();
        c_req = 4'b0010;
        wait_req(ok);
        check("cfg_req_seen", 32'(ok), 32'd1);
        @(negedge clk_in);
        cfg_div = 16'd7; cfg_div_we = 1'b1;
        @(negedge clk_in);
        cfg_div_we = 1'b0;
        check("cfg_busy_set", 32'(cfg_busy), 32'd1);
        cfg_div = 16'd3; cfg_div_we = 1'b1;
        @(negedge clk_in);
        cfg_div_we = 1'b0;
        wait_done(1, ok, cyc, extra);
        c_req = '0;
        check("cfg_xfer_done", 32'(ok), 32'd1);
        check("cfg_xfer_rd", rd_data, ~mo[1]);
        check("cfg_after_xfer", 32'(m_nrst), 32'd1);
        ptr_m = 2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            r_nrst[i] = m_nrst; r_req[i] = m_request; r_nb[i] = m_nbits;
            r_mosi[i] = m_mosi_data; r_busy[i] = cfg_busy;
        end
        for (int i = 0; i < 2; i++) begin
            check("cfg_nrst_low", 32'(r_nrst[i]), 32'd0);
            check("cfg_request", 32'(r_req[i]), 32'd1);
            check("cfg_nbits", 32'(r_nb[i]), 32'd0);
            check("cfg_mosi", r_mosi[i], 32'h0000_0003);
        end
        check("cfg_rel_nrst", 32'(r_nrst[2]), 32'd0);
        check("cfg_rel_req", 32'(r_req[2]), 32'd0);
        check("cfg_rel_busy", 32'(r_busy[2]), 32'd1);
        check("cfg_end_nrst", 32'(r_nrst[3]), 32'd1);
        check("cfg_end_busy", 32'(r_busy[3]), 32'd0);
        check("master_div", 32'(mdiv), 32'd3);

        // Watchdog abort with the master hung, then the other client is served.
        nb[0] = 5'd6; mo[0] = $urandom; nb[1] = 5'd11; mo[1] = $urandom;
        apply_fields();
        hang  = 1'b1;
        mask  = 4'b0011;
        c_req = mask;
        g = model_pick(mask, ptr_m);
        wait_req(ok);
        check("wd_req_seen", 32'(ok), 32'd1);
        check("wd_gnt", 32'(c_gnt), 32'(1 << g));
        ok = 1'b0; cyc = 0;
        while (!ok && cyc < BUDGET) begin
            @(negedge clk_in);
            cyc++;
            if (c_err[g]) ok = 1'b1;
        end
        check("wd_err_seen", 32'(ok), 32'd1);
        check("wd_err_cycle", cyc, TO + 1);
        check("wd_no_done", 32'(c_done), 32'd0);
        c_req[g] = 1'b0;
        hang = 1'b0;
        ptr_m = (g + 1) % N;
        check("wd_nrst_low0", 32'(m_nrst), 32'd0);
        @(negedge clk_in);
        check("wd_nrst_low1", 32'(m_nrst), 32'd0);
        @(negedge clk_in);
        check("wd_nrst_high", 32'(m_nrst), 32'd1);
        o = model_pick(c_req, ptr_m);
        do_one(o, ~mo[o], 1'b1);

        // Randomized request patterns against the reference model.
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < N; i++) begin
                nb[i] = 5'($urandom_range(0, 31)); mo[i] = $urandom; s3[i] = 1'($urandom);
            end
            apply_fields();
            run_xfers(4'($urandom_range(1, 15)), $urandom_range(1, 4));
        end

        // Async reset during WAIT.
        c_req = 4'b1000;
        wait_req(ok);
        check("rstw_req_seen", 32'(ok), 32'd1);
        @(negedge clk_in);
        #2 nrst = 1'b0;
        #1;
        check("rstw_gnt", 32'(c_gnt), 32'd0);
        check("rstw_m_nrst", 32'(m_nrst), 32'd0);
        check("rstw_m_nbits", 32'(m_nbits), 32'd0);
        check("rstw_m_mosi", m_mosi_data, 32'd0);
        check("rstw_rd_data", rd_data, 32'd0);
        check("rstw_flags", {29'd0, cfg_busy, m_request, m_spi3w}, 32'd0);
        c_req = '0;
        @(negedge clk_in);
        nrst  = 1'b1;
        ptr_m = 0;
        @(negedge clk_in);
        check("rstw_release", 32'(m_nrst), 32'd1);
        run_xfers(4'b0110, 2);

        check("gnt_onehot", gnt_viol, 0);
        check("err_pulse_count", err_pulses, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL time_limit actual=expired required=finish");
        $fatal(1, "time limit");
    end

endmodule
